rca_att_programmer: RTL and testbench
=====================================

RCA_ATT_PROGRAMMER -- requirements
Module: rca_att_programmer

Interface
REQ-001 SHALL have parameter: NUM_RCAS, 4, number of trigger-table entries.
REQ-002 SHALL have parameter: XLEN, 32, address/data width.
REQ-003 SHALL have ports: clk  in  1  single clock; every flop is clocked on the rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: req_valid  in  1  configuration request present.
REQ-006 SHALL have ports: req_ready  out  1  programmer can accept a request.
REQ-007 SHALL have ports: req_rca_id  in  $clog2(NUM_RCAS)+1  target entry; the extra MSB allows out-of-range detection.
REQ-008 SHALL have ports: req_enable  in  1  1=install trigger, 0=remove trigger.
REQ-009 SHALL have ports: req_sbb_addr, req_loop_start_addr  in  XLEN  trigger contents.
REQ-010 SHALL have ports: att_wr_valid  out  1  field write offered to trigger table.
REQ-011 SHALL have ports: att_ready  in  1  trigger table can take a write.
REQ-012 SHALL have ports: att_field_id  out  2  field select: 0=SBB addr, 1=loop start, 2=valid.
REQ-013 SHALL have ports: att_rca_addr  out  $clog2(NUM_RCAS)  entry index.
REQ-014 SHALL have ports: att_field_value  out  XLEN  write data.
REQ-015 SHALL have ports: att_done  in  1  table reports write complete.
REQ-016 SHALL have ports: att_ack  out  1  acknowledge of att_done.
REQ-017 SHALL have ports: resp_valid  out  1  one-cycle completion pulse.
REQ-018 SHALL have ports: resp_err  out  1  qualifies resp_valid; request rejected.

Function
REQ-019 SHALL accept a request in a cycle with req_valid && req_ready, register all req_* fields, and deassert req_ready until resp_valid.
REQ-020 SHALL define states IDLE, WR_INV, WAIT_INV, WR_SBB, WAIT_SBB, WR_LOOP, WAIT_LOOP, WR_VAL, WAIT_VAL, RESP.
REQ-021 SHALL set req_ready=1 only in IDLE.
REQ-022 SHALL move from IDLE on acceptance: to RESP with resp_err=1 if req_rca_id >= NUM_RCAS, otherwise to WR_INV.
REQ-023 SHALL, in each WR_* state, drive att_wr_valid=1 with the state's field id, the registered entry, and value: WR_INV field 2 value 0; WR_SBB field 0 sbb; WR_LOOP field 1 loop_start; WR_VAL field 2 value 1.
REQ-024 SHALL hold att_wr_valid and its payload stable until att_ready=1, then advance to the matching WAIT_* state on the next cycle.
REQ-025 SHALL drive att_ack = att_done combinationally in WAIT_* states only, and advance when att_done=1.
REQ-026 SHALL order transitions WAIT_INV->WR_SBB (enable=1) or ->RESP (enable=0), WAIT_SBB->WR_LOOP, WAIT_LOOP->WR_VAL, and WAIT_VAL->RESP.
REQ-027 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; it SHALL never issue a write while resp_valid is high.
REQ-028 SHALL always invalidate first, so the entry is never valid with mixed old/new addresses.
REQ-029 SHALL ignore att_done outside WAIT_* states (att_ack=0 there).
REQ-030 SHALL drive att_field_value and att_rca_addr to 0 whenever att_wr_valid=0.

Reset
REQ-031 SHALL, with rst=1 at any state including mid-sequence, go to IDLE next cycle.
REQ-032 SHALL reset outputs to req_ready=1 (after reset), att_wr_valid=0, att_ack=0, resp_valid=0, resp_err=0, and payload 0.
REQ-033 SHALL drop any in-flight request without a response.

Configuration
REQ-034 SHALL, with RCA_ATT_PROG_SHADOW_EN defined, keep a NUM_RCAS-entry shadow {valid, sbb, loop} updated on each completed sequence and cleared on rst.
REQ-035 SHALL, with RCA_ATT_PROG_SHADOW_EN defined, go IDLE->RESP with resp_err=0 and no writes for any request that exactly matches the shadow (enable=1 with equal addresses and valid=1, or enable=0 with valid=0).
REQ-036 SHALL, with RCA_ATT_PROG_SHADOW_EN undefined, instantiate no shadow and always perform the full sequence.

Verification
REQ-037 SHALL test: enable id=1 sbb=0x1000 loop=0x0F00, att_ready=1, att_done one cycle after each write -> writes (2,0),(0,0x1000),(1,0x0F00),(2,1) to entry 1, resp_valid=1, resp_err=0.
REQ-038 SHALL test: disable id=3 -> single write field 2 value 0 to entry 3, then resp_valid.
REQ-039 SHALL test: req_rca_id=4 -> no att_wr_valid, resp_valid=1 with resp_err=1 one cycle after acceptance.
REQ-040 SHALL test: att_ready held 0 for 5 cycles in WR_SBB -> att_wr_valid and payload stable throughout, and exactly one write counted.
REQ-041 SHALL test: rst asserted in WAIT_LOOP -> IDLE next cycle, no resp_valid, and a new request is accepted afterwards.
REQ-042 SHALL test, with RCA_ATT_PROG_SHADOW_EN defined: repeat the REQ-037 request -> zero writes and resp_valid one cycle after acceptance.

Source files
------------

// File: rtl/rca_att_programmer.sv
// rca_att_programmer
//   Programs one entry of the RCA trigger table through a field-write
//   handshake. Every request first clears the entry's valid field. For an
//   install it then writes the SBB address, the loop-start address, and
//   finally sets valid, so the table never holds a valid entry that mixes
//   old and new addresses.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_rca_id            target entry; the extra MSB flags out-of-range ids
//   req_enable            1 = install trigger, 0 = remove trigger
//   req_sbb_addr          trigger SBB address
//   req_loop_start_addr   trigger loop-start address
//   att_wr_valid/att_ready  field write offered / accepted by the table
//   att_field_id          0 = SBB addr, 1 = loop start, 2 = valid
//   att_rca_addr          entry index (0 when no write is offered)
//   att_field_value       write data (0 when no write is offered)
//   att_done/att_ack      table write-complete / acknowledge
//   resp_valid/resp_err   one-cycle completion pulse; err = rejected id
//
// Build option
//   RCA_ATT_PROG_SHADOW_EN : keep a shadow copy of every entry and answer
//   requests that would not change the table without issuing any writes.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | ready for a request
// WR_INV    | offer write: valid field = 0
// WAIT_INV  | wait for table to finish the invalidate
// WR_SBB    | offer write: SBB address
// WAIT_SBB  | wait for table to finish the SBB write
// WR_LOOP   | offer write: loop-start address
// WAIT_LOOP | wait for table to finish the loop-start write
// WR_VAL    | offer write: valid field = 1
// WAIT_VAL  | wait for table to finish the valid write
// RESP      | resp_valid pulse, then back to IDLE

module rca_att_programmer #(
  parameter int NUM_RCAS = 4,
  parameter int XLEN     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [$clog2(NUM_RCAS):0]   req_rca_id,
  input  logic                        req_enable,
  input  logic [XLEN-1:0]             req_sbb_addr,
  input  logic [XLEN-1:0]             req_loop_start_addr,
  output logic                        att_wr_valid,
  input  logic                        att_ready,
  output logic [1:0]                  att_field_id,
  output logic [$clog2(NUM_RCAS)-1:0] att_rca_addr,
  output logic [XLEN-1:0]             att_field_value,
  input  logic                        att_done,
  output logic                        att_ack,
  output logic                        resp_valid,
  output logic                        resp_err
);

  localparam int IDXW = $clog2(NUM_RCAS);
  localparam int IDW  = IDXW + 1;
  localparam logic [IDW-1:0] ID_LIMIT = IDW'(NUM_RCAS);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_INV, S_WAIT_INV, S_WR_SBB, S_WAIT_SBB,
    S_WR_LOOP, S_WAIT_LOOP, S_WR_VAL, S_WAIT_VAL, S_RESP
  } state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_rca_id;
  logic              r_enable;
  logic [XLEN-1:0]   r_sbb;
  logic [XLEN-1:0]   r_loop;
  logic              r_req_ready;
  logic              r_att_wr_valid;
  logic [1:0]        r_att_field_id;
  logic [IDXW-1:0]   r_att_rca_addr;
  logic [XLEN-1:0]   r_att_field_value;
  logic              r_resp_valid;
  logic              r_resp_err;

  logic w_in_wait;
  logic w_id_bad;
  logic w_shadow_hit;

  assign w_in_wait = (r_state == S_WAIT_INV)  || (r_state == S_WAIT_SBB) ||
                     (r_state == S_WAIT_LOOP) || (r_state == S_WAIT_VAL);
  assign w_id_bad  = (req_rca_id >= ID_LIMIT);

`ifdef RCA_ATT_PROG_SHADOW_EN
  logic            r_sh_valid [NUM_RCAS];
  logic [XLEN-1:0] r_sh_sbb   [NUM_RCAS];
  logic [XLEN-1:0] r_sh_loop  [NUM_RCAS];
  logic [IDXW-1:0] w_req_idx;
  logic            w_sh_wr;

  assign w_req_idx    = req_rca_id[IDXW-1:0];
  // A request is redundant when the table already holds exactly what it asks for.
  assign w_shadow_hit = !w_id_bad &&
                        (req_enable ? (r_sh_valid[w_req_idx] &&
                                       (r_sh_sbb[w_req_idx]  == req_sbb_addr) &&
                                       (r_sh_loop[w_req_idx] == req_loop_start_addr))
                                    : !r_sh_valid[w_req_idx]);
  // Shadow follows the table only once a whole sequence has completed.
  assign w_sh_wr = att_done &&
                   (((r_state == S_WAIT_INV) && !r_enable) || (r_state == S_WAIT_VAL));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        r_sh_valid[i] <= 1'b0;
        r_sh_sbb[i]   <= '0;
        r_sh_loop[i]  <= '0;
      end
    end else if (w_sh_wr) begin
      r_sh_valid[r_rca_id] <= (r_state == S_WAIT_VAL);
      r_sh_sbb[r_rca_id]   <= r_sbb;
      r_sh_loop[r_rca_id]  <= r_loop;
    end
  end
`else
  assign w_shadow_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_rca_id          <= '0;
      r_enable          <= 1'b0;
      r_sbb             <= '0;
      r_loop            <= '0;
      r_req_ready       <= 1'b1;
      r_att_wr_valid    <= 1'b0;
      r_att_field_id    <= 2'd0;
      r_att_rca_addr    <= '0;
      r_att_field_value <= '0;
      r_resp_valid      <= 1'b0;
      r_resp_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_rca_id    <= req_rca_id[IDXW-1:0];
          r_enable    <= req_enable;
          r_sbb       <= req_sbb_addr;
          r_loop      <= req_loop_start_addr;
          r_req_ready <= 1'b0;
          if (w_id_bad || w_shadow_hit) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_id_bad;
          end else begin
            r_state           <= S_WR_INV;
            r_att_wr_valid    <= 1'b1;
            r_att_field_id    <= 2'd2;
            r_att_rca_addr    <= req_rca_id[IDXW-1:0];
            r_att_field_value <= '0;
          end
        end
        S_WR_INV, S_WR_SBB, S_WR_LOOP, S_WR_VAL: if (att_ready) begin
          // Payload returns to zero as soon as the offer is taken.
          r_att_wr_valid    <= 1'b0;
          r_att_field_id    <= 2'd0;
          r_att_rca_addr    <= '0;
          r_att_field_value <= '0;
          case (r_state)
            S_WR_INV:  r_state <= S_WAIT_INV;
            S_WR_SBB:  r_state <= S_WAIT_SBB;
            S_WR_LOOP: r_state <= S_WAIT_LOOP;
            default:   r_state <= S_WAIT_VAL;
          endcase
        end
        S_WAIT_INV: if (att_done) begin
          if (r_enable) begin
            r_state           <= S_WR_SBB;
            r_att_wr_valid    <= 1'b1;
            r_att_field_id    <= 2'd0;
            r_att_rca_addr    <= r_rca_id;
            r_att_field_value <= r_sbb;
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        S_WAIT_SBB: if (att_done) begin
          r_state           <= S_WR_LOOP;
          r_att_wr_valid    <= 1'b1;
          r_att_field_id    <= 2'd1;
          r_att_rca_addr    <= r_rca_id;
          r_att_field_value <= r_loop;
        end
        S_WAIT_LOOP: if (att_done) begin
          r_state           <= S_WR_VAL;
          r_att_wr_valid    <= 1'b1;
          r_att_field_id    <= 2'd2;
          r_att_rca_addr    <= r_rca_id;
          r_att_field_value <= XLEN'(1);
        end
        S_WAIT_VAL: if (att_done) begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        default: begin
          r_state        <= S_IDLE;
          r_req_ready    <= 1'b1;
          r_att_wr_valid <= 1'b0;
          r_resp_valid   <= 1'b0;
          r_resp_err     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready       = r_req_ready;
  assign att_wr_valid    = r_att_wr_valid;
  assign att_field_id    = r_att_field_id;
  assign att_rca_addr    = r_att_rca_addr;
  assign att_field_value = r_att_field_value;
  assign att_ack         = w_in_wait && att_done;
  assign resp_valid      = r_resp_valid;
  assign resp_err        = r_resp_err;

endmodule

// File: tb/tb_rca_att_programmer.sv
module tb_rca_att_programmer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_rca_id;
  logic        req_enable;
  logic [31:0] req_sbb_addr;
  logic [31:0] req_loop_start_addr;
  logic        att_wr_valid;
  logic        att_ready;
  logic [1:0]  att_field_id;
  logic [1:0]  att_rca_addr;
  logic [31:0] att_field_value;
  logic        att_done;
  logic        att_ack;
  logic        resp_valid;
  logic        resp_err;

  logic        r_done_auto;
  logic        done_force;
  logic        hs_mon;
  int          n_vec;
  int          n_err;
  int          resp_cnt;
  int          wr_f[$];
  int          wr_a[$];
  logic [31:0] wr_v[$];

  assign att_done = r_done_auto | done_force;

  rca_att_programmer #(.NUM_RCAS(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rca_id(req_rca_id),
    .req_enable(req_enable), .req_sbb_addr(req_sbb_addr),
    .req_loop_start_addr(req_loop_start_addr),
    .att_wr_valid(att_wr_valid), .att_ready(att_ready), .att_field_id(att_field_id),
    .att_rca_addr(att_rca_addr), .att_field_value(att_field_value),
    .att_done(att_done), .att_ack(att_ack),
    .resp_valid(resp_valid), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Trigger-table model: log every accepted write and report done one cycle later.
  always @(posedge clk) begin
    hs_mon = 1'b0;
    if (!rst && att_wr_valid === 1'b1 && att_ready === 1'b1) begin
      hs_mon = 1'b1;
      wr_f.push_back(int'(att_field_id));
      wr_a.push_back(int'(att_rca_addr));
      wr_v.push_back(att_field_value);
    end
    if (!rst && resp_valid === 1'b1) resp_cnt++;
    #1;
    r_done_auto = hs_mon;
  end

  task automatic clear_log();
    wr_f.delete(); wr_a.delete(); wr_v.delete();
  endtask

  task automatic send_req(input logic [2:0] id, input logic en,
                          input logic [31:0] sbb, input logic [31:0] lp);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL send_req_ready id=%0d: got %b want 1", id, req_ready);
    end
    req_valid = 1'b1; req_rca_id = id; req_enable = en;
    req_sbb_addr = sbb; req_loop_start_addr = lp;
    @(posedge clk); #1;
    req_valid = 1'b0; req_rca_id = '0; req_enable = 1'b0;
    req_sbb_addr = '0; req_loop_start_addr = '0;
  endtask

  task automatic wait_resp(input int max_cyc, output bit got);
    int c = 0;
    while (c < max_cyc && resp_valid !== 1'b1) begin
      @(posedge clk); #1; c++;
    end
    got = (resp_valid === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_vec++;
    if ({req_ready, att_wr_valid, att_ack, resp_valid, resp_err} !== 5'b10000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 10000",
                        {req_ready, att_wr_valid, att_ack, resp_valid, resp_err});
    end
    n_vec++;
    if ({att_rca_addr, att_field_value} !== 34'd0) begin
      n_err++; $display("FAIL reset_payload: got addr=%0d val=%h want 0",
                        att_rca_addr, att_field_value);
    end
    rst = 1'b0;
    done_force = 1'b1; #1;
    n_vec++;
    if (att_ack !== 1'b0) begin
      n_err++; $display("FAIL idle_ack_ignored: got %b want 0", att_ack);
    end
    done_force = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({req_ready, att_wr_valid, resp_valid} !== 3'b100) begin
      n_err++; $display("FAIL idle_stays: got %b want 100",
                        {req_ready, att_wr_valid, resp_valid});
    end
  endtask

  task automatic test_enable();
    int exp_f[4] = '{2, 0, 1, 2};
    logic [31:0] exp_v[4] = '{32'h0, 32'h1000, 32'h0F00, 32'h1};
    bit got;
    clear_log();
    send_req(3'd1, 1'b1, 32'h1000, 32'h0F00);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (att_done === 1'b1) break;
    end
    n_vec++;
    if (att_done !== 1'b1 || att_ack !== 1'b1) begin
      n_err++; $display("FAIL enable_ack: got done=%b ack=%b want 1/1", att_done, att_ack);
    end
    wait_resp(60, got);
    n_vec++;
    if (!got || resp_err !== 1'b0) begin
      n_err++; $display("FAIL enable_resp: got valid=%b err=%b want 1/0", resp_valid, resp_err);
    end
    n_vec++;
    if (wr_f.size() != 4) begin
      n_err++; $display("FAIL enable_nwrites: got %0d want 4", wr_f.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < wr_f.size()) begin
        n_vec++;
        if (wr_f[i] != exp_f[i] || wr_a[i] != 1 || wr_v[i] !== exp_v[i]) begin
          n_err++; $display("FAIL enable_write%0d: got f=%0d a=%0d v=%h want f=%0d a=1 v=%h",
                            i, wr_f[i], wr_a[i], wr_v[i], exp_f[i], exp_v[i]);
        end
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_err++; $display("FAIL enable_pulse: got valid=%b ready=%b want 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_disable();
    bit got;
    clear_log();
    send_req(3'd3, 1'b1, 32'h3000, 32'h3100);
    wait_resp(60, got);
    n_vec++;
    if (!got || wr_f.size() != 4) begin
      n_err++; $display("FAIL install3: got resp=%b writes=%0d want 1/4", got, wr_f.size());
    end
    @(posedge clk); #1;
    clear_log();
    send_req(3'd3, 1'b0, 32'h0, 32'h0);
    wait_resp(40, got);
    n_vec++;
    if (!got || resp_err !== 1'b0) begin
      n_err++; $display("FAIL disable_resp: got valid=%b err=%b want 1/0", resp_valid, resp_err);
    end
    n_vec++;
    if (wr_f.size() != 1) begin
      n_err++; $display("FAIL disable_nwrites: got %0d want 1", wr_f.size());
    end else begin
      n_vec++;
      if (wr_f[0] != 2 || wr_a[0] != 3 || wr_v[0] !== 32'h0) begin
        n_err++; $display("FAIL disable_write: got f=%0d a=%0d v=%h want f=2 a=3 v=0",
                          wr_f[0], wr_a[0], wr_v[0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    clear_log();
    send_req(3'd4, 1'b1, 32'h4444, 32'h5555);
    n_vec++;
    if ({resp_valid, resp_err, att_wr_valid} !== 3'b110) begin
      n_err++; $display("FAIL oor_resp: got valid=%b err=%b wr=%b want 1/1/0",
                        resp_valid, resp_err, att_wr_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({resp_valid, resp_err, req_ready} !== 3'b001 || wr_f.size() != 0) begin
      n_err++; $display("FAIL oor_after: got valid=%b err=%b ready=%b writes=%0d want 0/0/1/0",
                        resp_valid, resp_err, req_ready, wr_f.size());
    end
  endtask

  task automatic test_stall();
    bit got;
    bit seen = 1'b0;
    int n_sbb = 0;
    clear_log();
    send_req(3'd2, 1'b1, 32'h2000, 32'h2100);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (att_wr_valid === 1'b1 && att_field_id === 2'd0) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL stall_reach_sbb: got timeout want WR_SBB offer");
    end
    att_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({att_wr_valid, att_field_id, att_rca_addr, att_field_value} !== {1'b1, 2'd0, 2'd2, 32'h2000}) begin
        n_err++; $display("FAIL stall_hold%0d: got wr=%b f=%0d a=%0d v=%h want 1/0/2/2000",
                          k, att_wr_valid, att_field_id, att_rca_addr, att_field_value);
      end
    end
    att_ready = 1'b1;
    wait_resp(60, got);
    foreach (wr_f[i]) if (wr_f[i] == 0) n_sbb++;
    n_vec++;
    if (!got || n_sbb != 1 || wr_f.size() != 4) begin
      n_err++; $display("FAIL stall_count: got resp=%b sbb_writes=%0d writes=%0d want 1/1/4",
                        got, n_sbb, wr_f.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit got;
    bit seen = 1'b0;
    int rc;
    int nw;
    clear_log();
    send_req(3'd0, 1'b1, 32'hA000, 32'hB000);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (att_wr_valid === 1'b1 && att_field_id === 2'd1) seen = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (!seen || {req_ready, att_wr_valid, resp_valid, att_field_value} !== {3'b100, 32'h0}) begin
      n_err++; $display("FAIL midrst_idle: got seen=%b ready=%b wr=%b resp=%b v=%h want 1/1/0/0/0",
                        seen, req_ready, att_wr_valid, resp_valid, att_field_value);
    end
    rst = 1'b0;
    rc = resp_cnt;
    nw = wr_f.size();
    repeat (5) begin @(posedge clk); #1; end
    n_vec++;
    if (resp_cnt != rc || wr_f.size() != nw) begin
      n_err++; $display("FAIL midrst_dropped: got resps=%0d writes=%0d want 0/0",
                        resp_cnt - rc, wr_f.size() - nw);
    end
    clear_log();
    send_req(3'd0, 1'b1, 32'hC000, 32'hD000);
    wait_resp(60, got);
    n_vec++;
    if (!got || resp_err !== 1'b0 || wr_f.size() != 4) begin
      n_err++; $display("FAIL midrst_new: got resp=%b err=%b writes=%0d want 1/0/4",
                        got, resp_err, wr_f.size());
    end else begin
      n_vec++;
      if (wr_v[1] !== 32'hC000 || wr_v[2] !== 32'hD000 || wr_a[3] != 0) begin
        n_err++; $display("FAIL midrst_data: got sbb=%h loop=%h a=%0d want C000/D000/0",
                          wr_v[1], wr_v[2], wr_a[3]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_repeat();
    bit got;
    clear_log();
    send_req(3'd1, 1'b1, 32'h1000, 32'h0F00);
    wait_resp(60, got);
    @(posedge clk); #1;
    clear_log();
    send_req(3'd1, 1'b1, 32'h1000, 32'h0F00);
`ifdef RCA_ATT_PROG_SHADOW_EN
    n_vec++;
    if ({resp_valid, resp_err, att_wr_valid} !== 3'b100) begin
      n_err++; $display("FAIL shadow_hit: got valid=%b err=%b wr=%b want 1/0/0",
                        resp_valid, resp_err, att_wr_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if (wr_f.size() != 0) begin
      n_err++; $display("FAIL shadow_nwrites: got %0d want 0", wr_f.size());
    end
`else
    wait_resp(60, got);
    n_vec++;
    if (!got || wr_f.size() != 4) begin
      n_err++; $display("FAIL repeat_full: got resp=%b writes=%0d want 1/4", got, wr_f.size());
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    n_vec = 0; n_err = 0; resp_cnt = 0;
    rst = 1'b1; req_valid = 1'b0; req_rca_id = '0; req_enable = 1'b0;
    req_sbb_addr = '0; req_loop_start_addr = '0;
    att_ready = 1'b1; done_force = 1'b0; r_done_auto = 1'b0;
    test_reset();
    test_enable();
    test_disable();
    test_out_of_range();
    test_stall();
    test_reset_mid();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
